// File: rtl/bus_arbiter_rr_pkg.sv
// Shared bus definitions for the round-robin bus arbiter: active-low levels,
// arbiter state encoding and the default master count.
package bus_arbiter_rr_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

  localparam int DEFAULT_N_MASTERS = 4;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Master-side bus arbitration signals, shared by the arbiter (slave modport)
// and the requesting masters (master modport).
interface bus_arbiter_rr_if #(
  parameter int N_MASTERS = bus_arbiter_rr_pkg::DEFAULT_N_MASTERS
);

  localparam int OWNER_W = $clog2(N_MASTERS);

  // Handshake: a master pulls m_req_[i] low and owns the bus from the first
  // cycle m_grnt_[i] is low until it raises m_req_[i]; owner/bus_busy mirror it.
  logic [N_MASTERS-1:0] m_req_;
  logic [N_MASTERS-1:0] m_grnt_;
  logic [OWNER_W-1:0]   owner;
  logic                 bus_busy;
  logic                 timeout_pls;
  logic [0:0]           arb_state;

  modport slave (
    input  m_req_,
    output m_grnt_,
    output owner,
    output bus_busy,
    output timeout_pls,
    output arb_state
  );

  modport master (
    output m_req_,
    input  m_grnt_,
    input  owner,
    input  bus_busy,
    input  timeout_pls,
    input  arb_state
  );

endinterface

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Round-robin pick: first set, non-excluded request searching upward from
// start_i with wrap-around at N_MASTERS-1.
module bus_arbiter_rr_rr_pick #(
  parameter int N_MASTERS = 4,
  parameter int OWNER_W   = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [OWNER_W-1:0]   start_i,
  input  logic [N_MASTERS-1:0] excl_i,
  output logic [OWNER_W-1:0]   winner_o,
  output logic                 found_o
);

  always_comb begin
    logic [OWNER_W:0] idx;
    winner_o = '0;
    found_o  = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      // One spare bit holds start+i before the explicit wrap, so N=3 maps 3->0.
      idx = {1'b0, start_i} + (OWNER_W+1)'(i);
      if (idx >= (OWNER_W+1)'(N_MASTERS)) idx = idx - (OWNER_W+1)'(N_MASTERS);
      if (!found_o && req_i[idx[OWNER_W-1:0]] && !excl_i[idx[OWNER_W-1:0]]) begin
        found_o  = 1'b1;
        winner_o = idx[OWNER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Registered round-robin bus arbiter for N active-low requesting masters.
// Optional forced revocation of long ownership under BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int N_MASTERS   = DEFAULT_N_MASTERS,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter_rr_if.slave bus
);

  localparam int OWNER_W = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n
    $error("bus_arbiter_rr: N_MASTERS must be 2..8");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("bus_arbiter_rr: TIMEOUT_CYC must be 2..65535");
  end

  logic [0:0]           state_q, state_d;
  logic [OWNER_W-1:0]   ptr_q, ptr_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [N_MASTERS-1:0] grnt_q, grnt_d;
  logic                 busy_q, busy_d;
  logic                 tpls_q, tpls_d;
  logic [N_MASTERS-1:0] mask_q;

  logic [N_MASTERS-1:0] req, excl, owner_oh;
  logic [OWNER_W-1:0]   pick_start, winner;
  logic                 found, owner_rel, revoke, new_grant;

  function automatic logic [OWNER_W-1:0] inc_mod(input logic [OWNER_W-1:0] v);
    return (v == OWNER_W'(N_MASTERS-1)) ? '0 : v + 1'b1;
  endfunction

  assign req        = ~bus.m_req_;
  assign owner_oh   = N_MASTERS'(1) << owner_q;
  assign owner_rel  = (bus.m_req_[owner_q] == DISABLE_);
  // In GRANT the search restarts after the owner, which is excluded.
  assign pick_start = (state_q == ARB_GRANT) ? inc_mod(owner_q) : ptr_q;
  assign excl       = mask_q | ((state_q == ARB_GRANT) ? owner_oh : '0);
  assign new_grant  = found && ((state_q == ARB_IDLE) || owner_rel || revoke);

  bus_arbiter_rr_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .OWNER_W   (OWNER_W)
  ) u_pick (
    .req_i    (req),
    .start_i  (pick_start),
    .excl_i   (excl),
    .winner_o (winner),
    .found_o  (found)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_MASTERS-1:0] mask_d;

  // A release on the timeout edge wins: revoke needs the owner still requesting.
  assign revoke = (state_q == ARB_GRANT) && !owner_rel &&
                  (cnt_q == CNT_W'(TIMEOUT_CYC-1));

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant)                   cnt_d = '0;
    else if (state_q == ARB_GRANT)   cnt_d = cnt_q + 1'b1;
    mask_d = (mask_q & ~bus.m_req_) | (revoke ? owner_oh : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end
`else
  assign revoke = 1'b0;
  assign mask_q = '0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grnt_d  = grnt_q;
    busy_d  = busy_q;
    tpls_d  = revoke;
    if (new_grant) begin
      state_d         = ARB_GRANT;
      owner_d         = winner;
      ptr_d           = inc_mod(winner);
      grnt_d          = '1;
      grnt_d[winner]  = ENABLE_;
      busy_d          = 1'b1;
    end else if ((state_q == ARB_GRANT) && (owner_rel || revoke)) begin
      state_d = ARB_IDLE;
      grnt_d  = '1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grnt_q  <= '1;
      busy_q  <= 1'b0;
      tpls_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grnt_q  <= grnt_d;
      busy_q  <= busy_d;
      tpls_q  <= tpls_d;
    end
  end

  assign bus.m_grnt_     = grnt_q;
  assign bus.owner       = owner_q;
  assign bus.bus_busy    = busy_q;
  assign bus.timeout_pls = tpls_q;
  assign bus.arb_state   = state_q;

endmodule
